// File: rtl/combinational_array_multiplier.sv
// -----------------------------------------------------------------------------
// combinational_array_multiplier
//
// Purpose:
//   Single-bit cell of an unsigned carry-save array multiplier. The cell ANDs
//   multiplicand bit a_i with multiplier bit x_i and full-adds that partial
//   product with the partial sum from above and the neighbouring carry. The
//   sum/carry path is purely combinational. A registered copy of the sum and
//   carry is provided for pipelined tilings.
//
// Ports:
//   clk         in   1  clock, used only by the registered copy
//   rst_n       in   1  asynchronous active-low reset of the registered copy
//   a_i         in   1  multiplicand bit
//   x_i         in   1  multiplier bit
//   Sum_in      in   1  partial sum from the cell above
//   Carry_in    in   1  carry from the neighbouring cell
//   en_i        in   1  capture enable for the registered copy
//   Sum_out     out  1  combinational sum
//   Carry_out   out  1  combinational carry
//   pp_o        out  1  combinational partial product a_i & x_i
//   Sum_q       out  1  registered Sum_out (1-cycle latency)
//   Carry_q     out  1  registered Carry_out (1-cycle latency)
//   carry_cnt_o out  8  saturating count of enabled cycles with Carry_out=1
//                       (present only with the macro below)
//
// Configuration:
//   COMBINATIONAL_ARRAY_MULTIPLIER_CARRY_CNT_EN adds carry_cnt_o and its
//   saturating counter. Without it the port and counter are absent.
// -----------------------------------------------------------------------------
module combinational_array_multiplier (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_i,
    input  logic       x_i,
    input  logic       Sum_in,
    input  logic       Carry_in,
    input  logic       en_i,
    output logic       Sum_out,
    output logic       Carry_out,
    output logic       pp_o,
    output logic       Sum_q,
    output logic       Carry_q
`ifdef COMBINATIONAL_ARRAY_MULTIPLIER_CARRY_CNT_EN
    ,
    output logic [7:0] carry_cnt_o
`endif
);

    logic pp_p0;

    // Stage p0: partial product and full add, no state
    always_comb begin
        pp_p0     = a_i & x_i;
        Sum_out   = pp_p0 ^ Sum_in ^ Carry_in;
        Carry_out = (pp_p0 & Sum_in) | (pp_p0 & Carry_in) | (Sum_in & Carry_in);
    end

    assign pp_o = pp_p0;

    // Stage p1: registered copy for pipelined tilings
    logic sum_p1;
    logic carry_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_p1   <= 1'b0;
            carry_p1 <= 1'b0;
        end else if (en_i) begin
            sum_p1   <= Sum_out;
            carry_p1 <= Carry_out;
        end
    end

    assign Sum_q   = sum_p1;
    assign Carry_q = carry_p1;

`ifdef COMBINATIONAL_ARRAY_MULTIPLIER_CARRY_CNT_EN
    // Counter sticks at all-ones instead of wrapping
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [7:0] carry_cnt_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_cnt_p1 <= 8'd0;
        end else if (en_i && Carry_out) begin
            carry_cnt_p1 <= sat_inc(carry_cnt_p1);
        end
    end

    assign carry_cnt_o = carry_cnt_p1;
`endif

endmodule

// File: tb/tb_combinational_array_multiplier.sv
module tb_combinational_array_multiplier;

    logic clk;
    logic clk_run;
    logic rst_n;
    logic a_i, x_i, Sum_in, Carry_in, en_i;
    logic Sum_out, Carry_out, pp_o, Sum_q, Carry_q;
`ifdef COMBINATIONAL_ARRAY_MULTIPLIER_CARRY_CNT_EN
    logic [7:0] carry_cnt_o;
`endif

    int vectors;
    int miscompares;

    // Expected state of the registered outputs
    logic       exp_sq;
    logic       exp_cq;
    int         exp_cnt;

    combinational_array_multiplier dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_i       (a_i),
        .x_i       (x_i),
        .Sum_in    (Sum_in),
        .Carry_in  (Carry_in),
        .en_i      (en_i),
        .Sum_out   (Sum_out),
        .Carry_out (Carry_out),
        .pp_o      (pp_o),
        .Sum_q     (Sum_q),
        .Carry_q   (Carry_q)
`ifdef COMBINATIONAL_ARRAY_MULTIPLIER_CARRY_CNT_EN
        ,
        .carry_cnt_o (carry_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    typedef struct {
        logic a;
        logic x;
        logic s;
        logic c;
        logic e_sum;
        logic e_carry;
    } vec_t;

    vec_t tbl[6];

    // Reference: the cell is a one-bit multiply followed by a 3-input add
    function automatic int ref_add(input logic a, input logic x, input logic s, input logic c);
        return (a && x ? 1 : 0) + (s ? 1 : 0) + (c ? 1 : 0);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic a, input logic x, input logic s, input logic c, input logic e);
        a_i = a; x_i = x; Sum_in = s; Carry_in = c; en_i = e;
    endtask

    task automatic check_comb(input string name);
        int r;
        r = ref_add(a_i, x_i, Sum_in, Carry_in);
        check({name, ".sum"},   int'(Sum_out),   r % 2);
        check({name, ".carry"}, int'(Carry_out), r / 2);
        check({name, ".pp"},    int'(pp_o),      (a_i && x_i) ? 1 : 0);
    endtask

    task automatic check_regs(input string name);
        check({name, ".sum_q"},   int'(Sum_q),   int'(exp_sq));
        check({name, ".carry_q"}, int'(Carry_q), int'(exp_cq));
`ifdef COMBINATIONAL_ARRAY_MULTIPLIER_CARRY_CNT_EN
        check({name, ".cnt"}, int'(carry_cnt_o), exp_cnt);
`endif
    endtask

    // One rising edge, with the expected register state advanced alongside
    task automatic tick();
        int r;
        r = ref_add(a_i, x_i, Sum_in, Carry_in);
        @(posedge clk);
        if (rst_n && en_i) begin
            exp_sq = (r % 2) == 1;
            exp_cq = (r / 2) == 1;
            if (r / 2 == 1 && exp_cnt < 255) exp_cnt++;
        end
        #1;
    endtask

    task automatic async_reset_pulse();
        rst_n = 1'b0;
        #1;
        exp_sq = 1'b0; exp_cq = 1'b0; exp_cnt = 0;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        clk_run = 1'b0;
        exp_sq = 1'b0; exp_cq = 1'b0; exp_cnt = 0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        // Reset state with clock stopped
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #2;
        check_regs("reset");

        // Directed table, clock idle
        for (int i = 0; i < 6; i++) begin
            set_in(tbl[i].a, tbl[i].x, tbl[i].s, tbl[i].c, 1'b0);
            #2;
            check($sformatf("tbl%0d.sum", i),   int'(Sum_out),   int'(tbl[i].e_sum));
            check($sformatf("tbl%0d.carry", i), int'(Carry_out), int'(tbl[i].e_carry));
        end

        // Exhaustive combinational sweep, still in reset: outputs must not care
        for (int v = 0; v < 16; v++) begin
            set_in(v[3], v[2], v[1], v[0], v[0]);
            #2;
            check_comb($sformatf("exh%0d", v));
        end
        check_regs("reset_hold");

        // Release reset between edges, start clock
        rst_n = 1'b1;
        clk_run = 1'b1;
        #2;

        // Register path: capture 1111, then hold with en low
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        check_regs("cap1111");
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_regs("hold");
        check_comb("hold_comb");

        // Async reset mid-cycle: registers clear at once, comb path unaffected
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_sq = 1'b0; exp_cq = 1'b0; exp_cnt = 0;
        check_regs("async_rst");
        check_comb("async_rst_comb");
        // en ignored while in reset
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        check_regs("rst_en_ignored");
        #2;
        rst_n = 1'b1;
        tick();
        check_regs("first_capture");

        // Randomized cycles against the reference
        for (int n = 0; n < 400; n++) begin
            set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            #1;
            check_comb("rnd_comb");
            if ($urandom_range(0, 49) == 0) begin
                async_reset_pulse();
                check_regs("rnd_rst");
            end
            tick();
            check_regs("rnd_reg");
        end

`ifdef COMBINATIONAL_ARRAY_MULTIPLIER_CARRY_CNT_EN
        async_reset_pulse();
        check_regs("cnt_clear");
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 300; n++) tick();
        check("cnt_nocarry", int'(carry_cnt_o), 0);
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int n = 0; n < 10; n++) tick();
        check("cnt_ten", int'(carry_cnt_o), 10);
        for (int n = 10; n < 300; n++) tick();
        check("cnt_sat", int'(carry_cnt_o), 255);
        check_regs("cnt_end");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
